// File: rtl/logic_unit_seq_pkg.sv
// logic_unit_seq_pkg: opcodes, FSM states and sizing helper shared by the logic unit
package logic_unit_seq_pkg;
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOR  = 3'b010;
  localparam logic [2:0] OP_INV  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HOLD = 2'd2} state_t;
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/logic_unit_seq_slice_op.sv
// logic_slice_op: combinational SLICE-bit logic op built from per-bit gate primitives
module logic_slice_op
  import logic_unit_seq_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [2:0]       OP,
  input  logic [SLICE-1:0] A,
  input  logic [SLICE-1:0] B,
  output logic [SLICE-1:0] Y
);
  logic [SLICE-1:0] y_and, y_or, y_nor, y_inv, y_xor, y_nand;
  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    and  u_and  (y_and[i],  A[i], B[i]);
    or   u_or   (y_or[i],   A[i], B[i]);
    nor  u_nor  (y_nor[i],  A[i], B[i]);
    not  u_inv  (y_inv[i],  A[i]);
    xor  u_xor  (y_xor[i],  A[i], B[i]);
    nand u_nand (y_nand[i], A[i], B[i]);
  end
  // 110 and 111 both fall through to PASS
  always_comb begin
    Y = OP == OP_AND  ? y_and  :
        OP == OP_OR   ? y_or   :
        OP == OP_NOR  ? y_nor  :
        OP == OP_INV  ? y_inv  :
        OP == OP_XOR  ? y_xor  :
        OP == OP_NAND ? y_nand : A;
  end
endmodule

// File: rtl/logic_unit_seq.sv
// logic_unit_seq: multi-cycle bitwise logic unit, SLICE bits per cycle, valid/ready on both sides.
// Define LOGIC_UNIT_SEQ_ZERO_FLAG_EN to add the registered ZERO result flag.
module logic_unit_seq
  import logic_unit_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Y
`ifdef LOGIC_UNIT_SEQ_ZERO_FLAG_EN
  ,
  output logic             ZERO
`endif
);
  localparam int N  = (SLICE < 1) ? 1 : WIDTH / SLICE;
  localparam int CW = clog2_min1(N);
  if (SLICE < 1) begin : g_bad_slice
    $error("logic_unit_seq: SLICE must be at least 1");
  end else if (WIDTH % SLICE != 0) begin : g_bad_width
    $error("logic_unit_seq: WIDTH must be a multiple of SLICE");
  end
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic [2:0]       op_q, op_d;
  logic [SLICE-1:0] a_sl, b_sl, y_sl;
  logic             last;
  logic_slice_op #(.SLICE(SLICE)) u_slice (.OP(op_q), .A(a_sl), .B(b_sl), .Y(y_sl));
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CW'(k)) begin
        a_sl = a_q[k*SLICE +: SLICE];
        b_sl = b_q[k*SLICE +: SLICE];
      end
    end
    last    = cnt_q == CW'(N - 1);
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    y_d     = y_q;
    if (state_q == ST_IDLE && IN_VALID) begin
      a_d     = A;
      b_d     = B;
      op_d    = OP;
      cnt_d   = '0;
      state_d = ST_RUN;
    end
    if (state_q == ST_RUN) begin
      for (int k = 0; k < N; k++) begin
        if (cnt_q == CW'(k)) y_d[k*SLICE +: SLICE] = y_sl;
      end
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      state_d = last ? ST_HOLD : ST_RUN;
    end
    if (state_q == ST_HOLD && OUT_READY) state_d = ST_IDLE;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      y_q     <= y_d;
    end
  end
  assign IN_READY  = state_q == ST_IDLE;
  assign OUT_VALID = state_q == ST_HOLD;
  assign Y         = y_q;
`ifdef LOGIC_UNIT_SEQ_ZERO_FLAG_EN
  logic zero_q, zero_d;
  // sampled from the completed result on the RUN->HOLD edge
  assign zero_d = (state_q == ST_RUN && last) ? (y_d == '0) : zero_q;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) zero_q <= 1'b0;
    else      zero_q <= zero_d;
  end
  assign ZERO = zero_q;
`endif
endmodule

// File: tb/tb_logic_unit_seq.sv
// tb_logic_unit_seq: directed and randomised checks of logic_unit_seq at several WIDTH/SLICE points
module tb_logic_unit_seq;
  logic        clk = 1'b0;
  logic        rst_n, iv, ir, ov, ordy, zero;
  logic [2:0]  op;
  logic [31:0] a, b, y;
  logic        s_iv;
  logic [2:0]  s_op;
  logic [63:0] s_a, s_b, y64;
  logic [7:0]  y8;
  logic [31:0] y1;
  logic        ir64, ir8, ir1, ov64, ov8, ov1, z64, z8, z1;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  logic_unit_seq u_dut (.CLK(clk), .RST(rst_n), .IN_VALID(iv), .IN_READY(ir), .OP(op), .A(a), .B(b),
                        .OUT_VALID(ov), .OUT_READY(ordy), .Y(y)
`ifdef LOGIC_UNIT_SEQ_ZERO_FLAG_EN
                        , .ZERO(zero)
`endif
                        );
  logic_unit_seq #(.WIDTH(64), .SLICE(16)) u_w64 (.CLK(clk), .RST(rst_n), .IN_VALID(s_iv), .IN_READY(ir64),
    .OP(s_op), .A(s_a), .B(s_b), .OUT_VALID(ov64), .OUT_READY(1'b1), .Y(y64)
`ifdef LOGIC_UNIT_SEQ_ZERO_FLAG_EN
    , .ZERO(z64)
`endif
    );
  logic_unit_seq #(.WIDTH(8), .SLICE(8)) u_w8 (.CLK(clk), .RST(rst_n), .IN_VALID(s_iv), .IN_READY(ir8),
    .OP(s_op), .A(s_a[7:0]), .B(s_b[7:0]), .OUT_VALID(ov8), .OUT_READY(1'b1), .Y(y8)
`ifdef LOGIC_UNIT_SEQ_ZERO_FLAG_EN
    , .ZERO(z8)
`endif
    );
  logic_unit_seq #(.WIDTH(32), .SLICE(1)) u_w1 (.CLK(clk), .RST(rst_n), .IN_VALID(s_iv), .IN_READY(ir1),
    .OP(s_op), .A(s_a[31:0]), .B(s_b[31:0]), .OUT_VALID(ov1), .OUT_READY(1'b1), .Y(y1)
`ifdef LOGIC_UNIT_SEQ_ZERO_FLAG_EN
    , .ZERO(z1)
`endif
    );

`ifndef LOGIC_UNIT_SEQ_ZERO_FLAG_EN
  initial begin
    zero = 1'b0;
    z64 = 1'b0;
    z8 = 1'b0;
    z1 = 1'b0;
  end
`endif

  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] z);
    case (o)
      3'b000:  return x & z;
      3'b001:  return x | z;
      3'b010:  return ~(x | z);
      3'b011:  return ~x;
      3'b100:  return x ^ z;
      3'b101:  return ~(x & z);
      default: return x;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    logic took;
    int t;
    op = o;
    a = av;
    b = bv;
    iv = 1'b1;
    t = 0;
    do begin
      took = ir;
      @(posedge clk);
      #1;
      t++;
    end while (!took && t < 50);
    iv = 1'b0;
  endtask

  task automatic wait_ov(output int lat);
    lat = 0;
    while (!ov && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv = 1'b0;
    s_iv = 1'b0;
    ordy = 1'b1;
    op = '0;
    a = '0;
    b = '0;
    s_op = '0;
    s_a = '0;
    s_b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (ir !== 1'b1 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, need 1/0", ir, ov);
    end
    n_chk++;
    if (y !== 32'h0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_y: y=%h zero=%b, need 00000000/0", y, zero);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ops();
    logic [2:0]  ot[8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [31:0] at[8] = '{32'hFFFF0000, 32'hF0F00000, 32'h0, 32'h12345678, 32'hA5A5A5A5, 32'hFFFF0000, 32'hCAFEF00D, 32'hDEADBEEF};
    logic [31:0] bt[8] = '{32'h0F0F0F0F, 32'h000F0F0F, 32'h0, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'hFF00FF00, 32'h12345678, 32'h0};
    logic [31:0] et[8] = '{32'h0F0F0000, 32'hF0FF0F0F, 32'hFFFFFFFF, 32'hEDCBA987, 32'h0, 32'h00FFFFFF, 32'hCAFEF00D, 32'hDEADBEEF};
    int lat;
    for (int i = 0; i < 8; i++) begin
      issue(ot[i], at[i], bt[i]);
      wait_ov(lat);
      n_chk++;
      if (lat !== 4) begin
        n_fail++;
        $display("FAIL op%0d_latency: %0d cycles, need 4", i, lat);
      end
      n_chk++;
      if (y !== et[i]) begin
        n_fail++;
        $display("FAIL op%0d_y: y=%h, need %h", i, y, et[i]);
      end
`ifdef LOGIC_UNIT_SEQ_ZERO_FLAG_EN
      n_chk++;
      if (zero !== (et[i] == 32'h0)) begin
        n_fail++;
        $display("FAIL op%0d_zero: zero=%b, need %b", i, zero, et[i] == 32'h0);
      end
`endif
      @(posedge clk);
      #1;
      n_chk++;
      if (ir !== 1'b1 || ov !== 1'b0 || y !== et[i]) begin
        n_fail++;
        $display("FAIL op%0d_idle: in_ready=%b out_valid=%b y=%h, need 1/0/%h", i, ir, ov, y, et[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    issue(3'b000, 32'hFFFF0000, 32'h0F0F0F0F);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (ov !== 1'b0 || y !== 32'h0 || ir !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_reset: out_valid=%b y=%h in_ready=%b, need 0/00000000/1", ov, y, ir);
    end
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (ov || y !== 32'h0) seen = 1'b1;
    end
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL midrun_no_result: discarded transaction produced out_valid/y, need none");
    end
  endtask

  task automatic test_backpressure();
    int lat;
    ordy = 1'b0;
    issue(3'b001, 32'hF0F0F0F0, 32'h0000FFFF);
    wait_ov(lat);
    n_chk++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL bp_latency: %0d cycles, need 4", lat);
    end
    iv = 1'b1;
    op = 3'b000;
    b = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      a = 32'h11111111 * (i + 1);
      @(posedge clk);
      #1;
      n_chk++;
      if (ov !== 1'b1 || ir !== 1'b0 || y !== 32'hF0F0FFFF) begin
        n_fail++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b y=%h, need 1/0/f0f0ffff", i, ov, ir, y);
      end
    end
    a = 32'hFFFFFFFF;
    ordy = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (ov !== 1'b0 || ir !== 1'b1 || y !== 32'hF0F0FFFF) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b y=%h, need 0/1/f0f0ffff", ov, ir, y);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (ir !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: in_ready=%b, need 0", ir);
    end
    iv = 1'b0;
    a = 32'h0;
    b = 32'h0;
    op = 3'b011;
    wait_ov(lat);
    n_chk++;
    if (lat !== 4 || y !== 32'h12345678) begin
      n_fail++;
      $display("FAIL bp_second: latency=%0d y=%h, need 4/12345678", lat, y);
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] av, bv, e;
    int          lat;
    ordy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      o = 3'($urandom_range(0, 7));
      av = $urandom;
      bv = $urandom;
      e = 32'(ref_op(o, {32'h0, av}, {32'h0, bv}));
      issue(o, av, bv);
      wait_ov(lat);
      n_chk++;
      if (lat !== 4 || y !== e) begin
        n_fail++;
        $display("FAIL rand%0d op=%0d: latency=%0d y=%h, need 4/%h", i, o, lat, y, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sweep();
    logic [63:0] e, r64;
    logic [7:0]  r8;
    logic [31:0] r1;
    logic        q64, q8, q1;
    int          l64, l8, l1;
    for (int it = 0; it < 200; it++) begin
      s_op = 3'($urandom_range(0, 7));
      s_a = {$urandom, $urandom};
      s_b = {$urandom, $urandom};
      if (it == 0) s_b = s_a;
      if (it == 0) s_op = 3'b100;
      e = ref_op(s_op, s_a, s_b);
      n_chk++;
      if (!(ir64 && ir8 && ir1)) begin
        n_fail++;
        $display("FAIL sweep%0d_ready: in_ready 64/8/1=%b%b%b, need 111", it, ir64, ir8, ir1);
      end
      s_iv = 1'b1;
      @(posedge clk);
      #1;
      s_iv = 1'b0;
      l64 = 0;
      l8 = 0;
      l1 = 0;
      for (int c = 1; c <= 40 && (l64 == 0 || l8 == 0 || l1 == 0); c++) begin
        @(posedge clk);
        #1;
        if (ov64 && l64 == 0) begin l64 = c; r64 = y64; q64 = z64; end
        if (ov8 && l8 == 0) begin l8 = c; r8 = y8; q8 = z8; end
        if (ov1 && l1 == 0) begin l1 = c; r1 = y1; q1 = z1; end
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (l64 !== 4 || r64 !== e) begin
        n_fail++;
        $display("FAIL sweep%0d_w64: latency=%0d y=%h, need 4/%h", it, l64, r64, e);
      end
      n_chk++;
      if (l8 !== 1 || r8 !== e[7:0]) begin
        n_fail++;
        $display("FAIL sweep%0d_w8: latency=%0d y=%h, need 1/%h", it, l8, r8, e[7:0]);
      end
      n_chk++;
      if (l1 !== 32 || r1 !== e[31:0]) begin
        n_fail++;
        $display("FAIL sweep%0d_w32s1: latency=%0d y=%h, need 32/%h", it, l1, r1, e[31:0]);
      end
`ifdef LOGIC_UNIT_SEQ_ZERO_FLAG_EN
      n_chk++;
      if (q64 !== (e == 64'h0) || q8 !== (e[7:0] == 8'h0) || q1 !== (e[31:0] == 32'h0)) begin
        n_fail++;
        $display("FAIL sweep%0d_zero: zero 64/8/1=%b%b%b", it, q64, q8, q1);
      end
`endif
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ops();
    test_reset_mid_run();
    test_backpressure();
    test_random();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
